// File: rtl/lsu_issue_queue_if.sv
// Dispatch, write-back wakeup and LSU issue signals of the in-order LSU issue queue.
// The queue is the slave; dispatch/LSU side (or a bench) is the master.
interface lsu_issue_queue_if #(
    parameter int IDX_W  = 3,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
);
    logic                  flush;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [3:0]            disp_gen_op_type;
    logic [4:0]            disp_spec_op_type;
    logic                  disp_store_or_load;
    logic [1:0]            disp_bar_type;
    logic                  disp_imm_enable;
    logic [25:0]           disp_imm;
    logic [4:0]            disp_arch_rd;
    logic [PREG_W-1:0]     disp_preg_rd;
    logic [PREG_W-1:0]     disp_preg_rj;
    logic [PREG_W-1:0]     disp_preg_rk;
    logic                  disp_rd_exist;
    logic                  disp_rj_exist;
    logic                  disp_rk_exist;
    logic                  disp_rd_rdy;
    logic                  disp_rj_rdy;
    logic                  disp_rk_rdy;
    logic [ROB_W-1:0]      disp_rob_index;

    logic [1:0]            wb_valid;
    logic [2*PREG_W-1:0]   wb_preg;

    logic                  IQ_valid;
    logic                  FU_ready;
    logic [3:0]            gen_op_type;
    logic [4:0]            spec_op_type;
    logic                  store_or_load;
    logic [1:0]            bar_type;
    logic                  imm_enable;
    logic [25:0]           imm;
    logic [4:0]            arch_rd_index;
    logic [PREG_W-1:0]     preg_rd_index;
    logic [PREG_W-1:0]     preg_rj_index;
    logic [PREG_W-1:0]     preg_rk_index;
    logic                  reg_rd_exist;
    logic                  reg_rj_exist;
    logic                  reg_rk_exist;
    logic [ROB_W-1:0]      issued_lsu_index;
    logic [IDX_W:0]        occupancy;

    modport slave (
        input  flush, disp_valid, disp_gen_op_type, disp_spec_op_type, disp_store_or_load,
               disp_bar_type, disp_imm_enable, disp_imm, disp_arch_rd,
               disp_preg_rd, disp_preg_rj, disp_preg_rk,
               disp_rd_exist, disp_rj_exist, disp_rk_exist,
               disp_rd_rdy, disp_rj_rdy, disp_rk_rdy, disp_rob_index,
               wb_valid, wb_preg, FU_ready,
        output disp_ready, IQ_valid, gen_op_type, spec_op_type, store_or_load, bar_type,
               imm_enable, imm, arch_rd_index, preg_rd_index, preg_rj_index, preg_rk_index,
               reg_rd_exist, reg_rj_exist, reg_rk_exist, issued_lsu_index, occupancy
    );

    modport master (
        output flush, disp_valid, disp_gen_op_type, disp_spec_op_type, disp_store_or_load,
               disp_bar_type, disp_imm_enable, disp_imm, disp_arch_rd,
               disp_preg_rd, disp_preg_rj, disp_preg_rk,
               disp_rd_exist, disp_rj_exist, disp_rk_exist,
               disp_rd_rdy, disp_rj_rdy, disp_rk_rdy, disp_rob_index,
               wb_valid, wb_preg, FU_ready,
        input  disp_ready, IQ_valid, gen_op_type, spec_op_type, store_or_load, bar_type,
               imm_enable, imm, arch_rd_index, preg_rd_index, preg_rj_index, preg_rk_index,
               reg_rd_exist, reg_rj_exist, reg_rk_exist, issued_lsu_index, occupancy
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: circular buffer with PRF wakeup tracking; only the
// oldest entry is ever offered to the LSU.
module lsu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
) (
    input logic              clk,
    input logic              rst,
    lsu_issue_queue_if.slave q
);
    typedef struct packed {
        logic [3:0]        gen_op_type;
        logic [4:0]        spec_op_type;
        logic              store_or_load;
        logic [1:0]        bar_type;
        logic              imm_enable;
        logic [25:0]       imm;
        logic [4:0]        arch_rd;
        logic [PREG_W-1:0] preg_rd;
        logic [PREG_W-1:0] preg_rj;
        logic [PREG_W-1:0] preg_rk;
        logic              rd_exist;
        logic              rj_exist;
        logic              rk_exist;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] valid, rdy_rd, rdy_rj, rdy_rk;
    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   count;
    logic             full, enq, deq, head_ready;
    logic             rd_init, rj_init, rk_init;

    function automatic logic woken(input logic [PREG_W-1:0] p,
                                   input logic [1:0] v,
                                   input logic [2*PREG_W-1:0] w);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 2; i++)
            if (v[i] && w[i*PREG_W +: PREG_W] == p) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        full       = (count == (IDX_W+1)'(DEPTH));
        head_ready = valid[head] && rdy_rd[head] && rdy_rj[head] && rdy_rk[head];
        enq        = q.disp_valid && !full && !q.flush;
        deq        = head_ready && q.FU_ready && !q.flush;
        // Same-cycle write-back counts as ready so the new entry never misses it.
        rd_init = !q.disp_rd_exist || (q.disp_preg_rd == '0) || q.disp_rd_rdy
                  || woken(q.disp_preg_rd, q.wb_valid, q.wb_preg);
        rj_init = !q.disp_rj_exist || (q.disp_preg_rj == '0) || q.disp_rj_rdy
                  || woken(q.disp_preg_rj, q.wb_valid, q.wb_preg);
        rk_init = !q.disp_rk_exist || (q.disp_preg_rk == '0) || q.disp_rk_rdy
                  || woken(q.disp_preg_rk, q.wb_valid, q.wb_preg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            valid  <= '0;
            rdy_rd <= '0;
            rdy_rj <= '0;
            rdy_rk <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (q.flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            valid  <= '0;
            rdy_rd <= '0;
            rdy_rj <= '0;
            rdy_rk <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid[i] && woken(mem[i].preg_rd, q.wb_valid, q.wb_preg)) rdy_rd[i] <= 1'b1;
                if (valid[i] && woken(mem[i].preg_rj, q.wb_valid, q.wb_preg)) rdy_rj[i] <= 1'b1;
                if (valid[i] && woken(mem[i].preg_rk, q.wb_valid, q.wb_preg)) rdy_rk[i] <= 1'b1;
            end
            if (deq) begin
                valid[head]  <= 1'b0;
                rdy_rd[head] <= 1'b0;
                rdy_rj[head] <= 1'b0;
                rdy_rk[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            if (enq) begin
                mem[tail]    <= '{q.disp_gen_op_type, q.disp_spec_op_type, q.disp_store_or_load,
                                  q.disp_bar_type, q.disp_imm_enable, q.disp_imm, q.disp_arch_rd,
                                  q.disp_preg_rd, q.disp_preg_rj, q.disp_preg_rk,
                                  q.disp_rd_exist, q.disp_rj_exist, q.disp_rk_exist,
                                  q.disp_rob_index};
                valid[tail]  <= 1'b1;
                rdy_rd[tail] <= rd_init;
                rdy_rj[tail] <= rj_init;
                rdy_rk[tail] <= rk_init;
                tail         <= tail + 1'b1;
            end
            count <= count + (IDX_W+1)'(enq) - (IDX_W+1)'(deq);
        end
    end

    assign q.disp_ready       = !full;
    assign q.IQ_valid         = head_ready;
    assign q.occupancy        = count;
    assign q.gen_op_type      = mem[head].gen_op_type;
    assign q.spec_op_type     = mem[head].spec_op_type;
    assign q.store_or_load    = mem[head].store_or_load;
    assign q.bar_type         = mem[head].bar_type;
    assign q.imm_enable       = mem[head].imm_enable;
    assign q.imm              = mem[head].imm;
    assign q.arch_rd_index    = mem[head].arch_rd;
    assign q.preg_rd_index    = mem[head].preg_rd;
    assign q.preg_rj_index    = mem[head].preg_rj;
    assign q.preg_rk_index    = mem[head].preg_rk;
    assign q.reg_rd_exist     = mem[head].rd_exist;
    assign q.reg_rj_exist     = mem[head].rj_exist;
    assign q.reg_rk_exist     = mem[head].rk_exist;
    assign q.issued_lsu_index = mem[head].rob;
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: directed scenarios plus random traffic, all
// checked against a queue-based model of the issue rules.
module tb_lsu_issue_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [3:0]  gen;
        logic [4:0]  spec;
        logic        sl;
        logic [1:0]  bar;
        logic        imm_en;
        logic [25:0] imm;
        logic [4:0]  arch_rd;
        logic [5:0]  prd, prj, prk;
        logic        erd, erj, erk;
        logic [4:0]  rob;
    } op_t;

    typedef struct {
        op_t op;
        bit  r_rd, r_rj, r_rk;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_issue_queue_if #(.IDX_W(3), .PREG_W(6), .ROB_W(5)) bus ();

    lsu_issue_queue #(.DEPTH(DEPTH), .IDX_W(3), .PREG_W(6), .ROB_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    op_t        dop;
    logic       dv, rrd, rrj, rrk, fu, fl;
    logic [1:0] wbv;
    logic [5:0] wbp0, wbp1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input logic [5:0] p);
        return (wbv[0] && wbp0 == p) || (wbv[1] && wbp1 == p);
    endfunction

    function automatic bit head_ready();
        return mq.size() > 0 && mq[0].r_rd && mq[0].r_rj && mq[0].r_rk;
    endfunction

    function automatic op_t plain_op(input logic [4:0] rob, input logic st);
        op_t o;
        o         = '0;
        o.gen     = 4'h3;
        o.spec    = 5'(rob + 5'd2);
        o.sl      = st;
        o.imm     = 26'h12340 + 26'(rob);
        o.arch_rd = rob;
        o.rob     = rob;
        return o;
    endfunction

    task automatic idle();
        dv = 0; rrd = 0; rrj = 0; rrk = 0; fu = 0; fl = 0;
        wbv = '0; wbp0 = '0; wbp1 = '0; dop = '0;
    endtask

    task automatic model_update();
        bit   go, take;
        ent_t e;
        if (fl) begin
            mq.delete();
            return;
        end
        go   = head_ready() && fu;
        take = dv && mq.size() < DEPTH;
        foreach (mq[i]) begin
            if (hit(mq[i].op.prd)) mq[i].r_rd = 1;
            if (hit(mq[i].op.prj)) mq[i].r_rj = 1;
            if (hit(mq[i].op.prk)) mq[i].r_rk = 1;
        end
        if (go) void'(mq.pop_front());
        if (take) begin
            e.op   = dop;
            e.r_rd = !dop.erd || dop.prd == 0 || rrd || hit(dop.prd);
            e.r_rj = !dop.erj || dop.prj == 0 || rrj || hit(dop.prj);
            e.r_rk = !dop.erk || dop.prk == 0 || rrk || hit(dop.prk);
            mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        check("occupancy", 128'(bus.occupancy), 128'(mq.size()));
        check("disp_ready", 128'(bus.disp_ready), 128'(mq.size() < DEPTH));
        check("IQ_valid", 128'(bus.IQ_valid), 128'(head_ready()));
        if (mq.size() > 0) begin
            check("head_fields",
                  128'({bus.gen_op_type, bus.spec_op_type, bus.store_or_load, bus.bar_type,
                        bus.imm_enable, bus.imm, bus.arch_rd_index, bus.preg_rd_index,
                        bus.preg_rj_index, bus.preg_rk_index, bus.reg_rd_exist,
                        bus.reg_rj_exist, bus.reg_rk_exist, bus.issued_lsu_index}),
                  128'(mq[0].op));
        end
    endtask

    // Drive current stimulus, advance the model, clock once, compare.
    task automatic step();
        bus.flush              = fl;
        bus.disp_valid         = dv;
        bus.disp_gen_op_type   = dop.gen;
        bus.disp_spec_op_type  = dop.spec;
        bus.disp_store_or_load = dop.sl;
        bus.disp_bar_type      = dop.bar;
        bus.disp_imm_enable    = dop.imm_en;
        bus.disp_imm           = dop.imm;
        bus.disp_arch_rd       = dop.arch_rd;
        bus.disp_preg_rd       = dop.prd;
        bus.disp_preg_rj       = dop.prj;
        bus.disp_preg_rk       = dop.prk;
        bus.disp_rd_exist      = dop.erd;
        bus.disp_rj_exist      = dop.erj;
        bus.disp_rk_exist      = dop.erk;
        bus.disp_rd_rdy        = rrd;
        bus.disp_rj_rdy        = rrj;
        bus.disp_rk_rdy        = rrk;
        bus.disp_rob_index     = dop.rob;
        bus.wb_valid           = wbv;
        bus.wb_preg            = {wbp1, wbp0};
        bus.FU_ready           = fu;
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic random_stim();
        dv   = ($urandom_range(0, 9) < 6);
        dop  = op_t'({$urandom, $urandom, $urandom});
        dop.prd = 6'($urandom_range(0, 7));
        dop.prj = 6'($urandom_range(0, 7));
        dop.prk = 6'($urandom_range(0, 7));
        rrd  = ($urandom_range(0, 3) == 0);
        rrj  = ($urandom_range(0, 3) == 0);
        rrk  = ($urandom_range(0, 3) == 0);
        wbv  = 2'($urandom);
        wbp0 = 6'($urandom_range(0, 7));
        wbp1 = 6'($urandom_range(0, 7));
        fu   = ($urandom_range(0, 9) < 6);
        fl   = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        idle();
        step();
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupancy", 128'(bus.occupancy), 128'(0));
        check("rst_disp_ready", 128'(bus.disp_ready), 128'(1));
        check("rst_IQ_valid", 128'(bus.IQ_valid), 128'(0));
        check("rst_fields", 128'({bus.gen_op_type, bus.imm, bus.issued_lsu_index}), 128'(0));
        rst = 1'b0;
        mq.delete();

        // Load waits for rj wakeup, issues the cycle after write-back.
        idle();
        dv = 1; dop = plain_op(5'd1, 1'b0);
        dop.erd = 1; dop.prd = 6'd3; rrd = 1;
        dop.erj = 1; dop.prj = 6'd5;
        step();
        idle();
        repeat (3) begin
            step();
            check("t1_stall", 128'(bus.IQ_valid), 128'(0));
        end
        wbv = 2'b01; wbp0 = 6'd5;
        step();
        idle();
        check("t1_wake", 128'(bus.IQ_valid), 128'(1));
        fu = 1;
        step();
        check("t1_drain", 128'(bus.occupancy), 128'(0));

        // Stalled store at head blocks a ready younger load.
        idle();
        dv = 1; dop = plain_op(5'd2, 1'b1); dop.erd = 1; dop.prd = 6'd7;
        step();
        idle();
        dv = 1; dop = plain_op(5'd3, 1'b0);
        step();
        idle();
        step();
        check("t2_no_bypass", 128'(bus.IQ_valid), 128'(0));
        wbv = 2'b01; wbp0 = 6'd7;
        step();
        idle();
        check("t2_st_first", 128'(bus.issued_lsu_index), 128'(2));
        fu = 1;
        step();
        check("t2_ld_next", 128'({bus.IQ_valid, bus.issued_lsu_index}), 128'({1'b1, 5'd3}));
        step();

        // Same-cycle bypass on write-back port 1.
        idle();
        dv = 1; dop = plain_op(5'd4, 1'b0); dop.erj = 1; dop.prj = 6'd9;
        wbv = 2'b10; wbp1 = 6'd9;
        step();
        idle();
        check("t3_bypass", 128'(bus.IQ_valid), 128'(1));
        fu = 1;
        step();

        // Fill, reject a ninth offer, then drain in order.
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            dv = 1; dop = plain_op(5'(i), 1'b0);
            step();
        end
        dv = 1; dop = plain_op(5'd31, 1'b0);
        step();
        check("t4_full", 128'({bus.occupancy, bus.disp_ready}), 128'({4'd8, 1'b0}));
        idle();
        fu = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_order", 128'(bus.issued_lsu_index), 128'(i));
            step();
        end
        check("t4_empty", 128'(bus.occupancy), 128'(0));

        // Steady enqueue+dequeue at count 3 wraps the tail.
        idle();
        for (int i = 0; i < 3; i++) begin
            dv = 1; dop = plain_op(5'(10 + i), 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            dv = 1; fu = 1; dop = plain_op(5'(13 + i), 1'b0);
            step();
            check("t5_steady", 128'(bus.occupancy), 128'(3));
        end
        idle();
        fu = 1;
        repeat (3) step();

        // Flush drops the contents and the concurrent dispatch.
        idle();
        for (int i = 0; i < 5; i++) begin
            dv = 1; dop = plain_op(5'(i), 1'b0);
            step();
        end
        dv = 1; fl = 1; dop = plain_op(5'd20, 1'b0);
        step();
        check("t6_flush", 128'({bus.occupancy, bus.IQ_valid, bus.disp_ready}),
              128'({4'd0, 1'b0, 1'b1}));
        idle();
        dv = 1; dop = plain_op(5'd9, 1'b0);
        step();
        check("t6_new_head", 128'(bus.issued_lsu_index), 128'(9));

        // Random traffic with one asynchronous reset midway.
        for (int n = 0; n < 3000; n++) begin
            random_stim();
            step();
            if (n == 1500) begin
                idle();
                rst = 1'b1;
                #2;
                mq.delete();
                check("async_rst", 128'({bus.occupancy, bus.IQ_valid, bus.disp_ready}),
                      128'({4'd0, 1'b0, 1'b1}));
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
- In-order issue queue directly upstream of the LSU.
- Accepts memory-class micro-ops from dispatch/rename and tracks source-operand readiness through PRF write-back wakeups.
- Presents only the oldest entry to the LSU over the IQ_valid/FU_ready handshake, so loads, stores, LL/SC, PRELD, CACOP and barriers reach the LSU strictly in program order.
- A pipeline flush empties the queue.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 2.
- IDX_W, 3, log2(DEPTH); width of head/tail pointers.
- PREG_W, 6, physical register index width (PREG_INDEX_WIDTH).
- ROB_W, 5, ROB entry index width (ROB_ENTRY_INDEX_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  pipeline flush; empties the queue on the next edge.
- disp_valid  in  1  dispatch offers one micro-op.
- disp_ready  out  1  queue can accept; equals !full.
- disp_gen_op_type  in  4  general op type.
- disp_spec_op_type  in  5  specific op type.
- disp_store_or_load  in  1  1 = store-class op.
- disp_bar_type  in  2  barrier type.
- disp_imm_enable  in  1  immediate used.
- disp_imm  in  26  raw immediate field.
- disp_arch_rd  in  5  architectural rd.
- disp_preg_rd / disp_preg_rj / disp_preg_rk  in  PREG_W each  physical register indices.
- disp_rd_exist / disp_rj_exist / disp_rk_exist  in  1 each  operand present.
- disp_rd_rdy / disp_rj_rdy / disp_rk_rdy  in  1 each  operand already ready at rename.
- disp_rob_index  in  ROB_W  ROB tag.
- wb_valid  in  2  per-port PRF write-back valid.
- wb_preg  in  2*PREG_W  per-port written preg; port p uses bits [p*PREG_W +: PREG_W].
- IQ_valid  out  1  head entry is valid and ready to issue.
- FU_ready  in  1  LSU accepts this cycle.
- gen_op_type, spec_op_type, store_or_load, bar_type, imm_enable, imm, arch_rd_index, preg_rd_index, preg_rj_index, preg_rk_index, reg_rd_exist, reg_rj_exist, reg_rk_exist  out  same widths as disp_*  head entry fields, driven combinationally from head storage.
- issued_lsu_index  out  ROB_W  ROB tag of the head entry.
- occupancy  out  IDX_W+1  valid entry count, 0..DEPTH.

Behaviour:
- Storage: circular buffer with head, tail and count registers. Per entry: valid, all disp_* fields, and per-operand ready bits rdy_rd, rdy_rj, rdy_rk.
- Reset (async, rst=1):
  - head = tail = count = 0; all valid and ready bits cleared.
  - IQ_valid = 0, disp_ready = 1, occupancy = 0; head field outputs = 0.
- Enqueue when disp_valid && disp_ready: write entry[tail], tail++ (wraps mod DEPTH). Initial ready bit of operand x is 1 if any of:
  - !disp_x_exist;
  - disp_preg_x == 0;
  - disp_x_rdy;
  - any wb_valid[p] with wb_preg[p] == disp_preg_x in the same cycle (same-cycle wakeup bypass).
- Wakeup: every cycle, each valid entry sets rdy_x when any wb_valid[p] matches preg_x. Ready bits are sticky until dequeue.
- Issue:
  - IQ_valid = entry[head].valid && rdy_rd && rdy_rj && rdy_rk, computed from registered bits only, so issue follows wakeup by at least 1 cycle.
  - Stores require rd (store data) ready; barriers with no operands issue as soon as they are at the head.
  - Younger ready entries never bypass a stalled head.
- Dequeue when IQ_valid && FU_ready: clear entry[head].valid, head++ (wraps mod DEPTH).
- Count: count_next = count + enq − deq. Enqueue and dequeue in the same cycle leave count unchanged.
- Full (count == DEPTH): disp_ready = 0, even if a dequeue occurs that cycle (no same-cycle slot reuse). Dispatch offers while full are ignored.
- Empty: IQ_valid = 0; head outputs hold stale storage, which is don't-care.
- Flush has priority over enqueue, dequeue and wakeup. On the edge: head = tail = count = 0, all valid cleared. A dispatch offered in the flush cycle is dropped. IQ_valid stays 0 the cycle after flush.
- Output timing: head field outputs and IQ_valid are combinational from registers; no input-to-output combinational path except through the FU_ready-gated dequeue.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

Test Plan:
- Reset, then enqueue LD.W with rj=preg 5 not ready → IQ_valid=0 for 3 idle cycles. Then wb_valid[0]=1, wb_preg=5 → IQ_valid=1 on the next cycle; FU_ready=1 → occupancy 1→0.
- Enqueue ST.W (rd=7 not ready) followed by a fully ready LD.B → IQ_valid=0 (no bypass of the head). Wakeup preg 7 → ST issues first with issued_lsu_index = its ROB tag, then LD.B the following cycle.
- Same-cycle bypass: dispatch rj=9 not ready while wb_preg[1]=9 valid → IQ_valid=1 the next cycle.
- Fill 8 ready entries with FU_ready=0 → occupancy=8, disp_ready=0, a 9th offer is ignored. Then FU_ready=1 for 8 cycles → issue order is ROB tags 0..7, pointers wrap to 0, occupancy=0.
- Enqueue and dequeue in the same cycle with count=3 → count stays 3; tail wraps from 7 to 0 correctly.
- Flush with 5 entries plus a concurrent disp_valid → next cycle occupancy=0, IQ_valid=0, disp_ready=1. A new enqueue lands in entry 0.
